coalescing_write_buffer: RTL

COALESCING_WRITE_BUFFER -- requirements
Module: coalescing_write_buffer

---
 rtl/coalescing_write_buffer_if.sv | 53 +++++
 rtl/coalescing_write_buffer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/coalescing_write_buffer_if.sv
// Bus bundle for coalescing_write_buffer.
// Carries the control handshake (start/stop/done/idle), the word write port
// (wr_en/wr_addr/wr_data/wr_now/wr_ready/wr_valid), the line request port
// (wr_req_* plus almostfull back-pressure), the two response channels and the
// outstanding-request count.
//   master : driven by the producer/host side
//   slave  : driven by the write buffer
interface coalescing_write_buffer_if #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_OUT     = 8
);
    localparam int unsigned WORDS = CACHE_WIDTH / DATA_WIDTH;
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned CW    = $clog2(MAX_OUT) + 1;

    logic                      start;
    logic                      stop;
    logic                      done;
    logic                      wr_en;
    logic [ADDR_LMT+OFF_W-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic                      wr_now;
    logic                      wr_ready;
    logic                      wr_valid;
    logic [ADDR_LMT-1:0]       wr_req_addr;
    logic [MDATA-1:0]          wr_req_mdata;
    logic [CACHE_WIDTH-1:0]    wr_req_data;
    logic                      wr_req_en;
    logic                      wr_req_almostfull;
    logic                      wr_rsp0_valid;
    logic [MDATA-1:0]          wr_rsp0_mdata;
    logic                      wr_rsp1_valid;
    logic [MDATA-1:0]          wr_rsp1_mdata;
    logic [CW-1:0]             outstanding;
    logic                      idle;

    modport master (
        output start, stop, wr_en, wr_addr, wr_data, wr_now, wr_req_almostfull,
               wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        input  done, wr_ready, wr_valid, wr_req_addr, wr_req_mdata, wr_req_data,
               wr_req_en, outstanding, idle
    );

    modport slave (
        input  start, stop, wr_en, wr_addr, wr_data, wr_now, wr_req_almostfull,
               wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
        output done, wr_ready, wr_valid, wr_req_addr, wr_req_mdata, wr_req_data,
               wr_req_en, outstanding, idle
    );
endinterface

// File: rtl/coalescing_write_buffer.sv
// Coalescing write buffer: gathers word writes into one cache line and issues
// the line as a single request once it is full, a different line is addressed,
// wr_now is asserted or stop flushes it. Tracks issued-but-unacknowledged
// requests and throttles at MAX_OUT.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : coalescing_write_buffer_if.slave (all handshake and data signals)
// All bus outputs are registered except wr_ready.
module coalescing_write_buffer #(
    parameter int unsigned ADDR_LMT    = 20,
    parameter int unsigned MDATA       = 14,
    parameter int unsigned CACHE_WIDTH = 512,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_OUT     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    coalescing_write_buffer_if.slave  bus
);
    localparam int unsigned WORDS = CACHE_WIDTH / DATA_WIDTH;
    localparam int unsigned OFF_W = $clog2(WORDS);
    localparam int unsigned CW    = $clog2(MAX_OUT) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CACHE_WIDTH-1:0] line_q, line_d;
    logic [WORDS-1:0]       valid_q, valid_d;
    logic [ADDR_LMT-1:0]    laddr_q, laddr_d;
    logic                   drain_pend_q, drain_pend_d;
    logic [MDATA-1:0]       tag_q, tag_d;
    logic [CW-1:0]          out_q, out_d;
    logic                   done_q, done_d;
    logic                   wr_valid_q, wr_valid_d;
    logic                   req_en_q, req_en_d;
    logic [ADDR_LMT-1:0]    req_addr_q, req_addr_d;
    logic [MDATA-1:0]       req_mdata_q, req_mdata_d;
    logic [CACHE_WIDTH-1:0] req_data_q, req_data_d;
    logic                   idle_q, idle_d;

    logic [OFF_W-1:0]       lane;
    logic [ADDR_LMT-1:0]    line_in;
    logic                   line_open, mismatch, wr_ready, accept, can_issue, issue;
    logic                   open_after;
    logic [CW-1:0]          out_inc, rsp_n;
    logic [CACHE_WIDTH-1:0] masked;
    logic                   unused_rsp_mdata;

    // Response tags are not matched against issued tags.
    assign unused_rsp_mdata = ^{bus.wr_rsp0_mdata, bus.wr_rsp1_mdata};

    assign lane      = bus.wr_addr[OFF_W-1:0];
    assign line_in   = bus.wr_addr[ADDR_LMT+OFF_W-1:OFF_W];
    assign line_open = |valid_q;
    assign mismatch  = line_open && (line_in != laddr_q);
    assign wr_ready  = (state_q == StFill) && !mismatch;
    assign accept    = bus.wr_en && wr_ready;
    assign can_issue = !bus.wr_req_almostfull && (out_q < CW'(MAX_OUT));
    assign issue     = (state_q == StIssue) && can_issue;

    // Outstanding count: +1 per issue, -1 per response, floored at zero.
    always_comb begin
        out_inc = out_q + CW'(issue);
        rsp_n   = CW'(bus.wr_rsp0_valid) + CW'(bus.wr_rsp1_valid);
        if (rsp_n >= out_inc) out_d = '0;
        else                  out_d = out_inc - rsp_n;
    end

    always_comb begin
        masked = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (valid_q[w]) masked[w*DATA_WIDTH +: DATA_WIDTH] = line_q[w*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        valid_d      = valid_q;
        laddr_d      = laddr_q;
        drain_pend_d = drain_pend_q;
        tag_d        = tag_q;
        done_d       = 1'b0;
        wr_valid_d   = accept;
        req_en_d     = issue;
        req_addr_d   = req_addr_q;
        req_mdata_d  = req_mdata_q;
        req_data_d   = req_data_q;
        open_after   = line_open;

        case (state_q)
            StIdle: begin
                if (bus.start) state_d = StFill;
            end
            StFill: begin
                if (accept) begin
                    for (int unsigned w = 0; w < WORDS; w++) begin
                        if (lane == OFF_W'(w)) begin
                            line_d[w*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
                            valid_d[w] = 1'b1;
                        end
                    end
                    if (!line_open) laddr_d = line_in;
                end
                open_after = |valid_d;
                if (bus.stop) begin
                    if (open_after) begin
                        state_d      = StIssue;
                        drain_pend_d = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end else if ((bus.wr_en && mismatch) || (&valid_d) ||
                             (bus.wr_now && open_after)) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.stop) drain_pend_d = 1'b1;
                if (can_issue) begin
                    req_addr_d   = laddr_q;
                    req_mdata_d  = tag_q;
                    req_data_d   = masked;
                    tag_d        = tag_q + MDATA'(1);
                    line_d       = '0;
                    valid_d      = '0;
                    drain_pend_d = 1'b0;
                    state_d      = (drain_pend_q || bus.stop) ? StDrain : StFill;
                end
            end
            default: begin  // StDrain
                if (out_d == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase

        idle_d = (state_d == StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            line_q       <= '0;
            valid_q      <= '0;
            laddr_q      <= '0;
            drain_pend_q <= 1'b0;
            tag_q        <= '0;
            out_q        <= '0;
            done_q       <= 1'b0;
            wr_valid_q   <= 1'b0;
            req_en_q     <= 1'b0;
            req_addr_q   <= '0;
            req_mdata_q  <= '0;
            req_data_q   <= '0;
            idle_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            valid_q      <= valid_d;
            laddr_q      <= laddr_d;
            drain_pend_q <= drain_pend_d;
            tag_q        <= tag_d;
            out_q        <= out_d;
            done_q       <= done_d;
            wr_valid_q   <= wr_valid_d;
            req_en_q     <= req_en_d;
            req_addr_q   <= req_addr_d;
            req_mdata_q  <= req_mdata_d;
            req_data_q   <= req_data_d;
            idle_q       <= idle_d;
        end
    end

    assign bus.wr_ready     = wr_ready;
    assign bus.wr_valid     = wr_valid_q;
    assign bus.done         = done_q;
    assign bus.wr_req_en    = req_en_q;
    assign bus.wr_req_addr  = req_addr_q;
    assign bus.wr_req_mdata = req_mdata_q;
    assign bus.wr_req_data  = req_data_q;
    assign bus.outstanding  = out_q;
    assign bus.idle         = idle_q;
endmodule
